// File: rtl/l2_ahb_tx_sched.sv
// AHB-Lite master sequencer draining the L2 TX FIFO into an address window.
// Issues INCR4 bursts from 16-byte aligned offsets when four words are queued, SINGLE otherwise.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | bus idle; start a transfer or apply a (pending) clear
// S_ADDR     | address phase on bus; earlier beat's data phase may be pending
// S_DATA     | last beat's data phase, bus htrans already IDLE
// S_ERR_WAIT | first ERROR cycle seen, waiting for the second (hready=1)
// S_ERR      | halted after bus error until pin_l2_clr
module l2_ahb_tx_sched #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          WIN_BYTES = 4096,
    parameter int          LVL_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pin_l2_clr,
    input  logic             tx_fifo_empty,
    input  logic [LVL_W-1:0] tx_fifo_level,
    input  logic [31:0]      tx_fifo_dout,
    output logic             tx_fifo_rd_en,
    output logic [1:0]       m_ahb_htrans,
    output logic [2:0]       m_ahb_hsize,
    output logic [2:0]       m_ahb_hburst,
    output logic             m_ahb_hwrite,
    output logic [31:0]      m_ahb_haddr,
    output logic [31:0]      m_ahb_hwdata,
    input  logic             m_ahb_hready,
    input  logic [1:0]       m_ahb_hresp,
    output logic             busy,
    output logic             err,
    output logic [15:0]      xfer_cnt
);

    localparam int OFF_W = $clog2(WIN_BYTES);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR_WAIT,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       htrans_q, htrans_d;
    logic [2:0]       hburst_q, hburst_d;
    logic             hwrite_q, hwrite_d;
    logic [31:0]      haddr_q, haddr_d;
    logic [31:0]      hwdata_q, hwdata_d;
    logic [OFF_W-1:0] offset_q, offset_d;
    logic [1:0]       beats_q, beats_d;
    logic             data_pend_q, data_pend_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             clr_pend_q, clr_pend_d;

    logic [OFF_W-1:0] next_off;
    logic             beat_ok;
    logic             beat_err;
    logic             can_start;
    logic             burst_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            htrans_q    <= HTRANS_IDLE;
            hburst_q    <= HBURST_SINGLE;
            hwrite_q    <= 1'b0;
            haddr_q     <= BASE_ADDR;
            hwdata_q    <= 32'd0;
            offset_q    <= '0;
            beats_q     <= 2'd0;
            data_pend_q <= 1'b0;
            cnt_q       <= 16'd0;
            err_q       <= 1'b0;
            clr_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            hburst_q    <= hburst_d;
            hwrite_q    <= hwrite_d;
            haddr_q     <= haddr_d;
            hwdata_q    <= hwdata_d;
            offset_q    <= offset_d;
            beats_q     <= beats_d;
            data_pend_q <= data_pend_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            clr_pend_q  <= clr_pend_d;
        end
    end

    assign next_off  = offset_q + OFF_W'(4);
    assign beat_ok   = m_ahb_hready && (m_ahb_hresp == HRESP_OKAY);
    assign beat_err  = !m_ahb_hready && (m_ahb_hresp == HRESP_ERROR);
    assign can_start = !tx_fifo_empty && (tx_fifo_level != '0) && !err_q;
    assign burst_ok  = (tx_fifo_level >= LVL_W'(4)) && (offset_q[3:2] == 2'b00);

    always_comb begin
        state_d     = state_q;
        htrans_d    = htrans_q;
        hburst_d    = hburst_q;
        hwrite_d    = hwrite_q;
        haddr_d     = haddr_q;
        hwdata_d    = hwdata_q;
        offset_d    = offset_q;
        beats_d     = beats_q;
        data_pend_d = data_pend_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        clr_pend_d  = clr_pend_q;

        case (state_q)
            S_IDLE: begin
                // A clear takes the slot; a start waits for the following cycle.
                if (pin_l2_clr || clr_pend_q) begin
                    offset_d   = '0;
                    cnt_d      = 16'd0;
                    err_d      = 1'b0;
                    clr_pend_d = 1'b0;
                end else if (can_start) begin
                    htrans_d    = HTRANS_NONSEQ;
                    hwrite_d    = 1'b1;
                    haddr_d     = BASE_ADDR + 32'(offset_q);
                    data_pend_d = 1'b0;
                    state_d     = S_ADDR;
                    if (burst_ok) begin
                        hburst_d = HBURST_INCR4;
                        beats_d  = 2'd3;
                    end else begin
                        hburst_d = HBURST_SINGLE;
                        beats_d  = 2'd0;
                    end
                end
            end

            S_ADDR: begin
                if (pin_l2_clr) clr_pend_d = 1'b1;
                if (data_pend_q && beat_err) begin
                    htrans_d = HTRANS_IDLE;
                    hwrite_d = 1'b0;
                    state_d  = S_ERR_WAIT;
                end else if (m_ahb_hready) begin
                    if (data_pend_q && beat_ok) cnt_d = cnt_q + 16'd1;
                    hwdata_d    = tx_fifo_dout;
                    offset_d    = next_off;
                    data_pend_d = 1'b1;
                    if (beats_q != 2'd0) begin
                        htrans_d = HTRANS_SEQ;
                        haddr_d  = BASE_ADDR + 32'(next_off);
                        beats_d  = beats_q - 2'd1;
                    end else begin
                        htrans_d = HTRANS_IDLE;
                        hwrite_d = 1'b0;
                        state_d  = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (pin_l2_clr) clr_pend_d = 1'b1;
                if (beat_err) begin
                    state_d = S_ERR_WAIT;
                end else if (m_ahb_hready) begin
                    if (beat_ok) cnt_d = cnt_q + 16'd1;
                    data_pend_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            S_ERR_WAIT: begin
                if (pin_l2_clr) clr_pend_d = 1'b1;
                if (m_ahb_hready) begin
                    data_pend_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = S_ERR;
                end
            end

            S_ERR: begin
                if (pin_l2_clr || clr_pend_q) begin
                    offset_d   = '0;
                    cnt_d      = 16'd0;
                    err_d      = 1'b0;
                    clr_pend_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign tx_fifo_rd_en = (state_q == S_ADDR) && m_ahb_hready;
    assign m_ahb_htrans  = htrans_q;
    assign m_ahb_hsize   = 3'd2;
    assign m_ahb_hburst  = hburst_q;
    assign m_ahb_hwrite  = hwrite_q;
    assign m_ahb_haddr   = haddr_q;
    assign m_ahb_hwdata  = hwdata_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_ERR);
    assign err           = err_q;
    assign xfer_cnt      = cnt_q;

endmodule

// File: tb/tb_l2_ahb_tx_sched.sv
// Directed bench for l2_ahb_tx_sched: a 16-byte window so wrap is reachable, FIFO modelled by pointers.
// Each step drives inputs at the falling edge and checks the registered outputs just after.
module tb_l2_ahb_tx_sched;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          WIN  = 16;
    localparam int          LW   = 6;

    logic          clk;
    logic          rst_n;
    logic          pin_l2_clr;
    logic          tx_fifo_empty;
    logic [LW-1:0] tx_fifo_level;
    logic [31:0]   tx_fifo_dout;
    logic          tx_fifo_rd_en;
    logic [1:0]    m_ahb_htrans;
    logic [2:0]    m_ahb_hsize;
    logic [2:0]    m_ahb_hburst;
    logic          m_ahb_hwrite;
    logic [31:0]   m_ahb_haddr;
    logic [31:0]   m_ahb_hwdata;
    logic          m_ahb_hready;
    logic [1:0]    m_ahb_hresp;
    logic          busy;
    logic          err;
    logic [15:0]   xfer_cnt;

    l2_ahb_tx_sched #(.BASE_ADDR(BASE), .WIN_BYTES(WIN), .LVL_W(LW)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pin_l2_clr    (pin_l2_clr),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_fifo_level (tx_fifo_level),
        .tx_fifo_dout  (tx_fifo_dout),
        .tx_fifo_rd_en (tx_fifo_rd_en),
        .m_ahb_htrans  (m_ahb_htrans),
        .m_ahb_hsize   (m_ahb_hsize),
        .m_ahb_hburst  (m_ahb_hburst),
        .m_ahb_hwrite  (m_ahb_hwrite),
        .m_ahb_haddr   (m_ahb_haddr),
        .m_ahb_hwdata  (m_ahb_hwdata),
        .m_ahb_hready  (m_ahb_hready),
        .m_ahb_hresp   (m_ahb_hresp),
        .busy          (busy),
        .err           (err),
        .xfer_cnt      (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [64];
    int          wr_ptr = 0;
    int          rd_ptr;
    int          n_checks = 0;
    int          n_pass = 0;
    int          bad_pop = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_ptr <= 0;
        else if (tx_fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    always_comb begin
        tx_fifo_empty = (wr_ptr == rd_ptr);
        tx_fifo_level = LW'(wr_ptr - rd_ptr);
        tx_fifo_dout  = mem[rd_ptr[5:0]];
    end

    typedef struct {
        int          push;
        logic        rdy;
        logic [1:0]  resp;
        logic        clr;
        logic [1:0]  tr;
        logic [3:0]  off;
        int          wd;
        logic        rd;
        logic        bsy;
        logic        er;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] word_of(input int i);
        return (i < 0) ? 32'd0 : 32'hC0DE_0000 + 32'(i);
    endfunction

    function automatic void add(input int push, input logic rdy, input logic [1:0] resp,
                                input logic clr, input logic [1:0] tr, input logic [3:0] off,
                                input int wd, input logic rd, input logic bsy, input logic er,
                                input logic [15:0] cnt);
        vec_t v;
        v.push = push; v.rdy = rdy; v.resp = resp; v.clr = clr; v.tr = tr; v.off = off;
        v.wd = wd; v.rd = rd; v.bsy = bsy; v.er = er; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step(input string name, input vec_t v);
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        @(negedge clk);
        for (int k = 0; k < v.push; k++) begin
            mem[wr_ptr[5:0]] = word_of(wr_ptr);
            wr_ptr++;
        end
        m_ahb_hready = v.rdy;
        m_ahb_hresp  = v.resp;
        pin_l2_clr   = v.clr;
        #1;
        if (tx_fifo_rd_en && tx_fifo_empty) bad_pop++;
        e_addr = BASE + 32'(v.off);
        e_wd   = word_of(v.wd);
        n_checks++;
        if (m_ahb_htrans === v.tr && m_ahb_haddr === e_addr && m_ahb_hwdata === e_wd &&
            tx_fifo_rd_en === v.rd && busy === v.bsy && err === v.er && xfer_cnt === v.cnt &&
            m_ahb_hwrite === v.tr[1] && m_ahb_hsize === 3'd2)
            n_pass++;
        else
            $display("FAIL %s: got htrans=%b haddr=%h hwdata=%h rd_en=%b busy=%b err=%b cnt=%0d hwrite=%b hsize=%0d, expected htrans=%b haddr=%h hwdata=%h rd_en=%b busy=%b err=%b cnt=%0d hwrite=%b hsize=2",
                     name, m_ahb_htrans, m_ahb_haddr, m_ahb_hwdata, tx_fifo_rd_en, busy, err,
                     xfer_cnt, m_ahb_hwrite, m_ahb_hsize, v.tr, e_addr, e_wd, v.rd, v.bsy, v.er,
                     v.cnt, v.tr[1]);
    endtask

    task automatic s(input string name, input int push, input logic rdy, input logic [1:0] resp,
                     input logic clr, input logic [1:0] tr, input logic [3:0] off, input int wd,
                     input logic rd, input logic bsy, input logic er, input logic [15:0] cnt);
        vec_t v;
        v.push = push; v.rdy = rdy; v.resp = resp; v.clr = clr; v.tr = tr; v.off = off;
        v.wd = wd; v.rd = rd; v.bsy = bsy; v.er = er; v.cnt = cnt;
        step(name, v);
    endtask

    initial begin
        rst_n        = 1'b0;
        pin_l2_clr   = 1'b0;
        m_ahb_hready = 1'b1;
        m_ahb_hresp  = 2'b00;

        // push rdy resp clr | htrans off wd rd busy err cnt
        add(0, 1, 0, 0, 2'b00, 4'h0, -1, 0, 0, 0, 0);   // reset state
        add(4, 1, 0, 0, 2'b00, 4'h0, -1, 0, 0, 0, 0);   // INCR4, zero wait
        add(0, 1, 0, 0, 2'b10, 4'h0, -1, 1, 1, 0, 0);
        add(0, 1, 0, 0, 2'b11, 4'h4,  0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 2'b11, 4'h8,  1, 1, 1, 0, 1);
        add(0, 1, 0, 0, 2'b11, 4'hC,  2, 1, 1, 0, 2);
        add(0, 1, 0, 0, 2'b00, 4'hC,  3, 0, 1, 0, 3);
        add(3, 1, 0, 0, 2'b00, 4'hC,  3, 0, 0, 0, 4);   // three SINGLEs
        add(0, 1, 0, 0, 2'b10, 4'h0,  3, 1, 1, 0, 4);
        add(0, 1, 0, 0, 2'b00, 4'h0,  4, 0, 1, 0, 4);
        add(0, 1, 0, 0, 2'b00, 4'h0,  4, 0, 0, 0, 5);
        add(0, 1, 0, 0, 2'b10, 4'h4,  4, 1, 1, 0, 5);
        add(0, 1, 0, 0, 2'b00, 4'h4,  5, 0, 1, 0, 5);
        add(0, 1, 0, 0, 2'b00, 4'h4,  5, 0, 0, 0, 6);
        add(0, 1, 0, 0, 2'b10, 4'h8,  5, 1, 1, 0, 6);
        add(0, 1, 0, 0, 2'b00, 4'h8,  6, 0, 1, 0, 6);
        add(0, 1, 0, 1, 2'b00, 4'h8,  6, 0, 0, 0, 7);   // clear in IDLE
        add(5, 1, 0, 0, 2'b00, 4'h8,  6, 0, 0, 0, 0);   // INCR4 then wrapped SINGLE
        add(0, 1, 0, 0, 2'b10, 4'h0,  6, 1, 1, 0, 0);
        add(0, 1, 0, 0, 2'b11, 4'h4,  7, 1, 1, 0, 0);
        add(0, 1, 0, 0, 2'b11, 4'h8,  8, 1, 1, 0, 1);
        add(0, 1, 0, 0, 2'b11, 4'hC,  9, 1, 1, 0, 2);
        add(0, 1, 0, 0, 2'b00, 4'hC, 10, 0, 1, 0, 3);
        add(0, 1, 0, 0, 2'b00, 4'hC, 10, 0, 0, 0, 4);
        add(0, 1, 0, 0, 2'b10, 4'h0, 10, 1, 1, 0, 4);
        add(0, 1, 0, 0, 2'b00, 4'h0, 11, 0, 1, 0, 4);
        add(0, 1, 0, 1, 2'b00, 4'h0, 11, 0, 0, 0, 5);
        add(4, 1, 0, 0, 2'b00, 4'h0, 11, 0, 0, 0, 0);   // INCR4 with 2 wait states
        add(0, 1, 0, 0, 2'b10, 4'h0, 11, 1, 1, 0, 0);
        add(0, 1, 0, 0, 2'b11, 4'h4, 12, 1, 1, 0, 0);
        add(0, 0, 0, 0, 2'b11, 4'h8, 13, 0, 1, 0, 1);
        add(0, 0, 0, 0, 2'b11, 4'h8, 13, 0, 1, 0, 1);
        add(0, 1, 0, 0, 2'b11, 4'h8, 13, 1, 1, 0, 1);
        add(0, 1, 0, 0, 2'b11, 4'hC, 14, 1, 1, 0, 2);
        add(0, 1, 0, 0, 2'b00, 4'hC, 15, 0, 1, 0, 3);
        add(0, 1, 0, 0, 2'b00, 4'hC, 15, 0, 0, 0, 4);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step($sformatf("vec%0d", i), vecs[i]);
        chk("pops_after_table", 64'(rd_ptr), 64'd16);

        // Bus error on the second data phase of an INCR4
        s("err0", 4, 1, 2'b00, 0, 2'b00, 4'hC, 15, 0, 0, 0, 4);
        s("err1", 0, 1, 2'b00, 0, 2'b10, 4'h0, 15, 1, 1, 0, 4);
        chk("err1_hburst", 64'(m_ahb_hburst), 64'(3'b011));
        s("err2", 0, 1, 2'b00, 0, 2'b11, 4'h4, 16, 1, 1, 0, 4);
        s("err3", 0, 0, 2'b01, 0, 2'b11, 4'h8, 17, 0, 1, 0, 5);
        s("err4", 0, 1, 2'b01, 0, 2'b00, 4'h8, 17, 0, 1, 0, 5);
        s("err5", 0, 1, 2'b00, 0, 2'b00, 4'h8, 17, 0, 0, 1, 5);
        s("err6", 0, 1, 2'b00, 1, 2'b00, 4'h8, 17, 0, 0, 1, 5);
        chk("err_pops", 64'(rd_ptr), 64'd18);
        s("err7", 0, 1, 2'b00, 0, 2'b00, 4'h8, 17, 0, 0, 0, 0);
        s("err8", 0, 1, 2'b00, 0, 2'b10, 4'h0, 17, 1, 1, 0, 0);
        chk("err8_hburst", 64'(m_ahb_hburst), 64'(3'b000));
        s("err9", 0, 1, 2'b00, 0, 2'b00, 4'h0, 18, 0, 1, 0, 0);
        s("err10", 0, 1, 2'b00, 0, 2'b00, 4'h0, 18, 0, 0, 0, 1);
        s("err11", 0, 1, 2'b00, 0, 2'b10, 4'h4, 18, 1, 1, 0, 1);
        s("err12", 0, 1, 2'b00, 0, 2'b00, 4'h4, 19, 0, 1, 0, 1);

        // Clear during a SINGLE (offset reset visible) and during an INCR4
        s("clr0", 5, 1, 2'b00, 0, 2'b00, 4'h4, 19, 0, 0, 0, 2);
        s("clr1", 0, 1, 2'b00, 1, 2'b10, 4'h8, 19, 1, 1, 0, 2);
        chk("clr1_hburst", 64'(m_ahb_hburst), 64'(3'b000));
        s("clr2", 0, 1, 2'b00, 0, 2'b00, 4'h8, 20, 0, 1, 0, 2);
        s("clr3", 0, 1, 2'b00, 0, 2'b00, 4'h8, 20, 0, 0, 0, 3);
        s("clr4", 0, 1, 2'b00, 0, 2'b00, 4'h8, 20, 0, 0, 0, 0);
        s("clr5", 0, 1, 2'b00, 1, 2'b10, 4'h0, 20, 1, 1, 0, 0);
        chk("clr5_hburst", 64'(m_ahb_hburst), 64'(3'b011));
        s("clr6", 0, 1, 2'b00, 0, 2'b11, 4'h4, 21, 1, 1, 0, 0);
        s("clr7", 0, 1, 2'b00, 0, 2'b11, 4'h8, 22, 1, 1, 0, 1);
        s("clr8", 0, 1, 2'b00, 0, 2'b11, 4'hC, 23, 1, 1, 0, 2);
        s("clr9", 0, 1, 2'b00, 0, 2'b00, 4'hC, 24, 0, 1, 0, 3);
        s("clr10", 1, 1, 2'b00, 0, 2'b00, 4'hC, 24, 0, 0, 0, 4);
        s("clr11", 0, 1, 2'b00, 0, 2'b00, 4'hC, 24, 0, 0, 0, 0);
        s("clr12", 0, 1, 2'b00, 0, 2'b10, 4'h0, 24, 1, 1, 0, 0);
        s("clr13", 0, 1, 2'b00, 0, 2'b00, 4'h0, 25, 0, 1, 0, 0);
        s("clr14", 0, 1, 2'b00, 0, 2'b00, 4'h0, 25, 0, 0, 0, 1);

        chk("total_pops", 64'(rd_ptr), 64'd26);
        chk("fifo_drained", 64'(wr_ptr - rd_ptr), 64'd0);
        chk("pop_while_empty", 64'(bad_pop), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
